// File: rtl/dog_extrema_3x3.sv
// Streaming 3x3 local-extremum detector for one signed DoG layer.
// Two line buffers plus a window register array; results are registered one cycle after input.
module dog_extrema_3x3 #(
  parameter int unsigned COLS   = 640,
  parameter int unsigned ROWS   = 480,
  parameter int unsigned DW     = 10,
  parameter int unsigned THRESH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic          out_kpt,
  output logic          out_kpt_max,
  output logic [9:0]    out_x,
  output logic [8:0]    out_y,
  output logic          frame_done
);

  localparam int unsigned AW = $clog2(COLS);
  localparam logic [9:0] ColLast = 10'(COLS - 1);
  localparam logic [8:0] RowLast = 9'(ROWS - 1);
  localparam logic signed [DW-1:0] ThrPos = DW'(THRESH);
  localparam logic signed [DW-1:0] ThrNeg = -ThrPos;

  logic [9:0]    col_q;
  logic [8:0]    row_q;
  logic [AW-1:0] addr;

  logic [DW-1:0] line_m1 [COLS];
  logic [DW-1:0] line_m2 [COLS];

  // Left and centre columns of the next window; its right column arrives with the input.
  logic signed [DW-1:0] win_q [3][2];
  logic signed [DW-1:0] win   [3][3];
  logic signed [DW-1:0] centre;

  logic gt_all, lt_all, is_max, is_min;
  logic complete, last_centre;

  assign addr = col_q[AW-1:0];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
    end
    win[0][2] = $signed(line_m2[addr]);
    win[1][2] = $signed(line_m1[addr]);
    win[2][2] = $signed(in_data);
  end

  assign centre = win[1][1];

  // Strict compares against all eight neighbours; any tie disqualifies.
  always_comb begin
    gt_all = 1'b1;
    lt_all = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1)) begin
          if (!(centre > win[r][c])) gt_all = 1'b0;
          if (!(centre < win[r][c])) lt_all = 1'b0;
        end
      end
    end
  end

  assign is_max = gt_all && (centre > ThrPos);
  assign is_min = lt_all && (centre < ThrNeg);

  assign complete    = in_valid && (col_q >= 10'd2) && (row_q >= 9'd2);
  assign last_centre = (col_q == ColLast) && (row_q == RowLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_valid) begin
      if (col_q == ColLast) begin
        col_q <= '0;
        row_q <= (row_q == RowLast) ? '0 : row_q + 9'd1;
      end else begin
        col_q <= col_q + 10'd1;
      end
    end
  end

  // Line buffer contents need no reset; read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line_m2[addr] <= line_m1[addr];
      line_m1[addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win[r][1];
        win_q[r][1] <= win[r][2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_kpt     <= 1'b0;
      out_kpt_max <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      frame_done  <= 1'b0;
    end else begin
      out_valid  <= complete;
      frame_done <= complete && last_centre;
      if (complete) begin
        out_kpt     <= is_max || is_min;
        out_kpt_max <= is_max;
        out_x       <= col_q - 10'd1;
        out_y       <= row_q - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_dog_extrema_3x3.sv
// Directed bench for dog_extrema_3x3 on a small 8x6 frame with hand-placed peaks and dips.
module tb_dog_extrema_3x3;

  localparam int COLS   = 8;
  localparam int ROWS   = 6;
  localparam int DW     = 10;
  localparam int THRESH = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_kpt, out_kpt_max, frame_done;
  logic [9:0]    out_x;
  logic [8:0]    out_y;

  dog_extrema_3x3 #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .DW    (DW),
    .THRESH(THRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_kpt    (out_kpt),
    .out_kpt_max(out_kpt_max),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int img [ROWS][COLS];
  int bx = 0, by = 0;
  logic exp_v = 1'b0, exp_fd = 1'b0;
  int exp_x = 0, exp_y = 0;
  int res_cnt, kpt_cnt, fd_cnt;
  int k_first_x, k_first_y, k_first_max, k_last_x, k_last_y, k_last_max;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: check outputs caused by the previous input, then drive the next input.
  task automatic step(input logic v, input int d);
    @(negedge clk);
    check("out_valid", int'(out_valid), int'(exp_v));
    check("frame_done", int'(frame_done), int'(exp_fd));
    if (frame_done) fd_cnt++;
    if (exp_v) begin
      check("out_x", int'(out_x), exp_x);
      check("out_y", int'(out_y), exp_y);
      res_cnt++;
      if (out_kpt) begin
        if (kpt_cnt == 0) begin
          k_first_x = int'(out_x); k_first_y = int'(out_y); k_first_max = int'(out_kpt_max);
        end
        k_last_x = int'(out_x); k_last_y = int'(out_y); k_last_max = int'(out_kpt_max);
        kpt_cnt++;
      end else begin
        check("kpt_max_without_kpt", int'(out_kpt_max), 0);
      end
    end
    in_valid = v;
    in_data  = DW'(d);
    exp_v  = v && bx >= 2 && by >= 2;
    exp_x  = bx - 1;
    exp_y  = by - 1;
    exp_fd = exp_v && bx == COLS - 1 && by == ROWS - 1;
    if (v) begin
      if (bx == COLS - 1) begin
        bx = 0;
        by = (by == ROWS - 1) ? 0 : by + 1;
      end else begin
        bx++;
      end
    end
  endtask

  task automatic clear_img();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        img[y][x] = 0;
  endtask

  task automatic send_frame(input int gap_max);
    res_cnt = 0; kpt_cnt = 0; fd_cnt = 0;
    k_first_x = -1; k_first_y = -1; k_first_max = -1;
    k_last_x = -1; k_last_y = -1; k_last_max = -1;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        step(1'b1, img[y][x]);
        if (gap_max > 0) begin
          int g;
          g = $urandom_range(0, gap_max);
          for (int i = 0; i < g; i++) step(1'b0, $urandom_range(0, 1023));
        end
      end
    end
    step(1'b0, 0);
  endtask

  task automatic check_frame(input string name, input int ek, input int fx, input int fy,
                             input int fmax, input int lx, input int ly, input int lmax);
    check({name, " results"}, res_cnt, (COLS - 2) * (ROWS - 2));
    check({name, " frame_done count"}, fd_cnt, 1);
    check({name, " kpt count"}, kpt_cnt, ek);
    if (ek > 0) begin
      check({name, " first kpt x"}, k_first_x, fx);
      check({name, " first kpt y"}, k_first_y, fy);
      check({name, " first kpt max"}, k_first_max, fmax);
      check({name, " last kpt x"}, k_last_x, lx);
      check({name, " last kpt y"}, k_last_y, ly);
      check({name, " last kpt max"}, k_last_max, lmax);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " out_valid"}, int'(out_valid), 0);
    check({name, " out_kpt"}, int'(out_kpt), 0);
    check({name, " out_kpt_max"}, int'(out_kpt_max), 0);
    check({name, " out_x"}, int'(out_x), 0);
    check({name, " out_y"}, int'(out_y), 0);
    check({name, " frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    clear_img();
    send_frame(0);
    check_frame("flat", 0, 0, 0, 0, 0, 0, 0);
    check("flat last out_x", int'(out_x), 6);
    check("flat last out_y", int'(out_y), 4);

    clear_img(); img[2][3] = 20;
    send_frame(0);
    check_frame("peak", 1, 3, 2, 1, 3, 2, 1);

    clear_img(); img[3][4] = -20;
    send_frame(0);
    check_frame("dip", 1, 4, 3, 0, 4, 3, 0);

    clear_img(); img[3][4] = -3;
    send_frame(0);
    check_frame("dip at thresh", 0, 0, 0, 0, 0, 0, 0);

    clear_img(); img[3][4] = -4;
    send_frame(0);
    check_frame("dip past thresh", 1, 4, 3, 0, 4, 3, 0);

    clear_img(); img[2][3] = 3;
    send_frame(0);
    check_frame("peak at thresh", 0, 0, 0, 0, 0, 0, 0);

    clear_img(); img[2][3] = 20; img[2][4] = 20;
    send_frame(0);
    check_frame("tie", 0, 0, 0, 0, 0, 0, 0);

    // Saturated extremes against the opposite rail and against zero.
    clear_img(); img[2][2] = -512; img[3][5] = 511;
    send_frame(0);
    check_frame("saturated", 2, 2, 2, 0, 5, 3, 1);

    clear_img(); img[2][3] = 20;
    send_frame(5);
    check_frame("gapped peak", 1, 3, 2, 1, 3, 2, 1);

    // Partial frame of busy data, then reset and a clean peak frame.
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        img[y][x] = (x * 37 + y * 91) % 200 - 100;
    res_cnt = 0; kpt_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b1, img[i / COLS][i % COLS]);
    step(1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_v = 1'b0; exp_fd = 1'b0; bx = 0; by = 0;
    #1;
    check_reset_outputs("mid-frame reset");
    @(negedge clk);
    rst_n = 1'b1;
    clear_img(); img[2][3] = 20;
    send_frame(0);
    check_frame("after reset", 1, 3, 2, 1, 3, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
